// File: rtl/bullet_bill_manager.sv
// BulletBill slot owner: spawns bullets at Blockieee's cell, advances them one
// column per move tick, resolves DDAVER collisions and issues kill requests.
//
// state | meaning
// IDLE  | waiting for move_tick; fire requests are evaluated here
// STEP0 | advance / collide slot 0
// STEP1 | advance / collide slot 1
// STEP2 | advance / collide slot 2
module bullet_bill_manager #(
  parameter int NUM_BULLETS = 3,
  parameter int LAST_COL    = 15,
  parameter int LAST_ROW    = 10,
  parameter int SPAWN_COL   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_tick,
  input  logic        fire,
  input  logic [11:0] fire_color,
  input  logic [3:0]  blockieee,
  input  logic [11:0] ddavers [0:4][0:5],
  output logic [11:0] bulletBillColor [0:NUM_BULLETS-1],
  output logic [3:0]  bulletBillXLoc [0:NUM_BULLETS-1],
  output logic [3:0]  bulletBillYLoc [0:NUM_BULLETS-1],
  output logic        fire_ack,
  output logic        fire_drop,
  output logic        kill_valid,
  output logic [2:0]  kill_row,
  output logic [2:0]  kill_col
);
  typedef enum logic [1:0] {IDLE, STEP0, STEP1, STEP2} state_t;
  state_t state, state_nxt;

  logic [11:0] color_nxt [0:NUM_BULLETS-1];
  logic [3:0]  x_nxt [0:NUM_BULLETS-1];
  logic [3:0]  y_nxt [0:NUM_BULLETS-1];
  logic        ack_nxt, drop_nxt, kill_nxt;
  logic [2:0]  krow_nxt, kcol_nxt;

  logic        spawn_busy, have_free;
  logic [1:0]  free_idx;
  logic [1:0]  sidx;
  logic [11:0] s_color, dd_color;
  logic [3:0]  s_x, s_y, s_nx;
  logic [2:0]  dd_row, dd_col;
  logic        hit;

  // Descending scan so the lowest free index wins.
  always_comb begin
    spawn_busy = 1'b0;
    have_free  = 1'b0;
    free_idx   = 2'd0;
    for (int k = NUM_BULLETS-1; k >= 0; k--) begin
      if (bulletBillColor[k] == 12'd0) begin
        have_free = 1'b1;
        free_idx  = 2'(k);
      end else if (bulletBillXLoc[k] == 4'(SPAWN_COL) && bulletBillYLoc[k] == blockieee) begin
        spawn_busy = 1'b1;
      end
    end
  end

  always_comb begin
    case (state)
      STEP1:   sidx = 2'd1;
      STEP2:   sidx = 2'd2;
      default: sidx = 2'd0;
    endcase
    s_color  = bulletBillColor[sidx];
    s_x      = bulletBillXLoc[sidx];
    s_y      = bulletBillYLoc[sidx];
    s_nx     = s_x + 4'd1;
    dd_row   = s_y[3:1];
    dd_col   = s_nx[3:1] - 3'd2;
    dd_color = 12'd0;
    hit      = 1'b0;
    // DDAVERs only occupy odd rows and even columns from 4 upward.
    if (s_y[0] && !s_nx[0] && s_nx >= 4'd4 && dd_row <= 3'd4 && dd_col <= 3'd5) begin
      dd_color = ddavers[dd_row][dd_col];
      hit      = (dd_color != 12'd0);
    end
  end

  always_comb begin
    state_nxt = state;
    color_nxt = bulletBillColor;
    x_nxt     = bulletBillXLoc;
    y_nxt     = bulletBillYLoc;
    ack_nxt   = 1'b0;
    drop_nxt  = 1'b0;
    kill_nxt  = 1'b0;
    krow_nxt  = kill_row;
    kcol_nxt  = kill_col;
    case (state)
      IDLE: begin
        if (move_tick) begin
          state_nxt = STEP0;
          drop_nxt  = fire;
        end else if (fire) begin
          if (fire_color == 12'd0 || blockieee > 4'(LAST_ROW) || !have_free || spawn_busy) begin
            drop_nxt = 1'b1;
          end else begin
            color_nxt[free_idx] = fire_color;
            x_nxt[free_idx]     = 4'(SPAWN_COL);
            y_nxt[free_idx]     = blockieee;
            ack_nxt             = 1'b1;
          end
        end
      end
      default: begin
        drop_nxt = fire;
        case (state)
          STEP0:   state_nxt = STEP1;
          STEP1:   state_nxt = STEP2;
          default: state_nxt = IDLE;
        endcase
        if (s_color != 12'd0) begin
          if (s_x == 4'(LAST_COL) || hit) begin
            color_nxt[sidx] = 12'd0;
            x_nxt[sidx]     = 4'd0;
            y_nxt[sidx]     = 4'd0;
            if (s_x != 4'(LAST_COL) && dd_color == s_color) begin
              kill_nxt = 1'b1;
              krow_nxt = dd_row;
              kcol_nxt = dd_col;
            end
          end else begin
            x_nxt[sidx] = s_nx;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fire_ack   <= 1'b0;
      fire_drop  <= 1'b0;
      kill_valid <= 1'b0;
      kill_row   <= 3'd0;
      kill_col   <= 3'd0;
      for (int k = 0; k < NUM_BULLETS; k++) begin
        bulletBillColor[k] <= 12'd0;
        bulletBillXLoc[k]  <= 4'd0;
        bulletBillYLoc[k]  <= 4'd0;
      end
    end else begin
      state           <= state_nxt;
      fire_ack        <= ack_nxt;
      fire_drop       <= drop_nxt;
      kill_valid      <= kill_nxt;
      kill_row        <= krow_nxt;
      kill_col        <= kcol_nxt;
      bulletBillColor <= color_nxt;
      bulletBillXLoc  <= x_nxt;
      bulletBillYLoc  <= y_nxt;
    end
  end
endmodule

// File: doc/bullet_bill_manager.md
Name: bullet_bill_manager

Overview:
- Sequential game-state stage directly upstream of the graphics generator.
- Owns the three BulletBill slots and produces the per-slot color and grid X/Y arrays the renderer draws.
- Spawns bullets from Blockieee's cell, advances them one grid column per move tick, and resolves collisions against the DDAVER grid.
- Issues one-cycle kill requests to the DDAVER owner.

Parameters:
- NUM_BULLETS, 3, number of bullet slots (fixed at 3; renderer draws exactly three).
- LAST_COL, 15, rightmost visible grid column (640/40 - 1).
- LAST_ROW, 10, lowest playable grid row (row 11 is the buffer row).
- SPAWN_COL, 2, grid column where new bullets appear (one right of Blockieee).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- move_tick  input  1  one-cycle pulse; advance all active bullets one column.
- fire  input  1  one-cycle fire request.
- fire_color  input  12  RGB444 color of requested bullet; 0 means invalid.
- blockieee  input  4  player grid row.
- ddavers  input  12 x [0:4][0:5]  enemy colors; entry [r][c] sits at grid row 2r+1, column 2c+4; 0 = empty.
- bulletBillColor  output  12 x [0:2]  slot color; 0 = slot inactive.
- bulletBillXLoc  output  4 x [0:2]  slot grid column.
- bulletBillYLoc  output  4 x [0:2]  slot grid row.
- fire_ack  output  1  one-cycle pulse: fire accepted.
- fire_drop  output  1  one-cycle pulse: fire rejected.
- kill_valid  output  1  one-cycle pulse: clear DDAVER at kill_row/kill_col.
- kill_row  output  3  DDAVER row index 0..4.
- kill_col  output  3  DDAVER column index 0..5.

Behaviour:
- Reset (async, immediate):
  - All bulletBillColor/XLoc/YLoc = 0.
  - fire_ack, fire_drop, kill_valid, kill_row, kill_col = 0.
  - FSM = IDLE.
- FSM states: IDLE, STEP0, STEP1, STEP2.
  - IDLE -> STEP0 on move_tick.
  - STEP0 -> STEP1 -> STEP2 -> IDLE unconditionally, one cycle each.
  - STEPk processes slot k.
- move_tick when not IDLE: ignored, no side effect. Integration guarantees ticks are at least 4 cycles apart.
- Fire, evaluated only in IDLE with move_tick low:
  - Reject (fire_drop pulse next cycle, no state change) if any of:
    - fire_color == 0;
    - blockieee > LAST_ROW;
    - no inactive slot;
    - an active slot already occupies (SPAWN_COL, blockieee).
  - Otherwise take the lowest-index inactive slot. Next cycle it holds color = fire_color, X = SPAWN_COL, Y = blockieee, and fire_ack pulses.
- fire in STEPx, or in the same cycle as move_tick: fire_drop pulse next cycle.
- fire_ack and fire_drop are never high in the same cycle.
- Slot processing in STEPk (inactive slot: no change):
  - X == LAST_COL: slot freed (color, X, Y -> 0). No wrap-around.
  - Else nx = X+1. If Y is odd, nx is even, nx >= 4, and ddavers[Y>>1][(nx>>1)-2] != 0, then collision:
    - Colors equal: kill_valid = 1, kill_row = Y>>1, kill_col = (nx>>1)-2 in the next cycle; slot freed.
    - Colors differ: slot freed (absorbed), no kill.
  - No collision: X <= nx, color and Y unchanged.
- Timing and hold rules:
  - Outputs are registered; updates appear the cycle after the processing cycle.
  - kill_row and kill_col hold their last value while kill_valid is low.
  - At most one kill per cycle by construction.
- Bullets never share a cell: the spawn-occupancy check plus equal velocity guarantee this.
- ddavers is sampled combinationally in the processing cycle. The DDAVER owner applies the kill before the next move_tick.
- blockieee changes never move existing bullets.
- Reset asserted mid-STEP: all slots cleared immediately, any pending kill discarded.

Test Plan:
- Reset, then fire with fire_color=12'hF00, blockieee=3 -> next cycle fire_ack=1; slot0 = (F00, X=2, Y=3); slots 1–2 color 0.
- Four fires on rows 1, 2, 3, 4 with ticks between -> slots 0–2 filled, fourth yields fire_drop=1 with no state change. Fire with fire_color=0 -> fire_drop=1.
- Bullet F00 at (3,3), ddavers[1][0]=F00, move_tick -> within 4 cycles kill_valid=1, kill_row=1, kill_col=0; slot0 color 0. Repeat with ddavers[1][0]=0F0 -> slot freed, kill_valid stays 0.
- Bullet at X=15, move_tick -> slot freed, X/Y/color = 0; bullet at even row 4 passes X=4..15 with no collision regardless of ddavers.
- Fire asserted in the same cycle as move_tick, and in STEP1 -> fire_drop=1 both times; existing bullets advance exactly one column per tick.
- Assert rst during STEP1 with three active bullets -> all outputs 0 immediately. After release, fire is accepted into slot0.
